// File: rtl/level_play_ctrl.sv
// Level/play-period controller: sequences IDLE -> PLAY -> POST -> IDLE,
// counts desired symbols during play, advances the level and drives the
// seconds-remaining display.
module level_play_ctrl #(
   parameter int unsigned PLAY_SECONDS = 20,
   parameter int unsigned MAX_LEVEL    = 9
) (
   input  logic       Clk100M,
   input  logic       Reset,
   input  logic       tick1Hz,
   input  logic       startSig,
   input  logic       symValid,
   input  logic       symIsMagic,
   input  logic       levelComplete,
   output logic       postSig,
   output logic       genEnable,
   output logic [7:0] magicSymbolCount,
   output logic [3:0] level,
   output logic [7:0] timeSeg0,
   output logic [7:0] timeSeg1
);

   localparam int unsigned TIME_W = 7;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned LVL_W  = 4;
   localparam int unsigned DIG_W  = 4;
   localparam int unsigned SEG_W  = 8;

   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(99);
   localparam logic [SEG_W-1:0]  SEG_BLANK = 8'hFF;
   localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(PLAY_SECONDS);
   localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(MAX_LEVEL);
   localparam logic [LVL_W-1:0]  LVL_FIRST = LVL_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      POST = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [TIME_W-1:0]  time_left_q, time_left_d;
   logic [CNT_W-1:0]   magic_cnt_q, magic_cnt_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               post_sig_q, post_sig_d;
   logic               gen_en_q, gen_en_d;
   logic [SEG_W-1:0]   seg_tens_q, seg_tens_d;
   logic [SEG_W-1:0]   seg_units_q, seg_units_d;
   logic [DIG_W-1:0]   tens_dig, units_dig;

   // Active-low seven-segment encoding {dp,g,f,e,d,c,b,a}; non-digits blank.
   function automatic logic [SEG_W-1:0] int_to_seg(input logic [DIG_W-1:0] dig);
      logic [SEG_W-1:0] seg;
      case (dig)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Next-state, counters and registered-output precompute.
   always_comb begin
      state_d     = state_q;
      time_left_d = time_left_q;
      magic_cnt_d = magic_cnt_q;
      level_d     = level_q;
      post_sig_d  = 1'b0;
      gen_en_d    = 1'b0;
      seg_tens_d  = SEG_BLANK;
      seg_units_d = SEG_BLANK;
      tens_dig    = '0;
      units_dig   = '0;

      case (state_q)
         IDLE: begin
            if (startSig) begin
               state_d     = PLAY;
               time_left_d = TIME_INIT;
               magic_cnt_d = '0;
            end
         end
         PLAY: begin
            // Symbol on the final-tick cycle still counts.
            if (symValid && symIsMagic && (magic_cnt_q != CNT_MAX)) begin
               magic_cnt_d = magic_cnt_q + CNT_W'(1);
            end
            if (tick1Hz) begin
               if (time_left_q <= TIME_W'(1)) begin
                  state_d     = POST;
                  time_left_d = '0;
               end else begin
                  time_left_d = time_left_q - TIME_W'(1);
               end
            end
         end
         POST: begin
            // startSig in the same cycle is deliberately dropped.
            if (levelComplete) begin
               state_d = IDLE;
               if (level_q < LVL_MAX) begin
                  level_d = level_q + LVL_W'(1);
               end else begin
                  level_d = LVL_MAX;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      gen_en_d   = (state_d == PLAY);
      post_sig_d = (state_d == POST);

      tens_dig  = DIG_W'(time_left_d / TIME_W'(10));
      units_dig = DIG_W'(time_left_d % TIME_W'(10));
      if (state_d != IDLE) begin
         seg_tens_d  = int_to_seg(tens_dig);
         seg_units_d = int_to_seg(units_dig);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk100M) begin
      if (Reset) begin
         state_q     <= IDLE;
         time_left_q <= '0;
         magic_cnt_q <= '0;
         level_q     <= LVL_FIRST;
         post_sig_q  <= 1'b0;
         gen_en_q    <= 1'b0;
         seg_tens_q  <= SEG_BLANK;
         seg_units_q <= SEG_BLANK;
      end else begin
         state_q     <= state_d;
         time_left_q <= time_left_d;
         magic_cnt_q <= magic_cnt_d;
         level_q     <= level_d;
         post_sig_q  <= post_sig_d;
         gen_en_q    <= gen_en_d;
         seg_tens_q  <= seg_tens_d;
         seg_units_q <= seg_units_d;
      end
   end

   assign postSig          = post_sig_q;
   assign genEnable        = gen_en_q;
   assign magicSymbolCount = magic_cnt_q;
   assign level            = level_q;
   assign timeSeg0         = seg_tens_q;
   assign timeSeg1         = seg_units_q;

endmodule

// File: tb/tb_level_play_ctrl.sv
// Directed self-checking bench for level_play_ctrl (3-second play, MAX_LEVEL 9).
module tb_level_play_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       sym_valid = 1'b0;
   logic       sym_magic = 1'b0;
   logic       lvl_done = 1'b0;
   logic       post_sig;
   logic       gen_en;
   logic [7:0] magic_cnt;
   logic [3:0] level;
   logic [7:0] seg0;
   logic [7:0] seg1;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] S0 = 8'hC0;
   localparam logic [7:0] S1 = 8'hF9;
   localparam logic [7:0] S2 = 8'hA4;
   localparam logic [7:0] S3 = 8'hB0;
   localparam logic [7:0] SB = 8'hFF;

   level_play_ctrl #(
      .PLAY_SECONDS(3),
      .MAX_LEVEL   (9)
   ) dut (
      .Clk100M         (clk),
      .Reset           (rst),
      .tick1Hz         (tick),
      .startSig        (start),
      .symValid        (sym_valid),
      .symIsMagic      (sym_magic),
      .levelComplete   (lvl_done),
      .postSig         (post_sig),
      .genEnable       (gen_en),
      .magicSymbolCount(magic_cnt),
      .level           (level),
      .timeSeg0        (seg0),
      .timeSeg1        (seg1)
   );

   always #5 clk = ~clk;

   // One clock; outputs sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_done();
      lvl_done = 1'b1;
      step();
      lvl_done = 1'b0;
   endtask

   task automatic check_idle(input string tag, input logic [7:0] exp_lvl, input logic [7:0] exp_cnt);
      check({tag, "_post"}, 8'(post_sig), 8'd0);
      check({tag, "_gen"},  8'(gen_en),   8'd0);
      check({tag, "_lvl"},  8'(level),    exp_lvl);
      check({tag, "_cnt"},  magic_cnt,    exp_cnt);
      check({tag, "_seg0"}, seg0,         SB);
      check({tag, "_seg1"}, seg1,         SB);
   endtask

   initial begin
      logic [7:0] exp_lvl;

      // Reset state
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check_idle("reset", 8'd1, 8'd0);

      // Basic 3-second play: 03,02,01,00
      do_start();
      check("p1_gen",   8'(gen_en),   8'd1);
      check("p1_post",  8'(post_sig), 8'd0);
      check("p1_seg0",  seg0, S0);
      check("p1_seg1",  seg1, S3);
      do_done();
      check("lc_in_play_post", 8'(post_sig), 8'd0);
      check("lc_in_play_gen",  8'(gen_en),   8'd1);
      check("lc_in_play_seg1", seg1, S3);
      do_tick();
      check("t1_seg1", seg1, S2);
      do_tick();
      check("t2_seg1", seg1, S1);
      check("t2_gen",  8'(gen_en), 8'd1);
      do_tick();
      check("t3_post", 8'(post_sig), 8'd1);
      check("t3_gen",  8'(gen_en),   8'd0);
      check("t3_seg0", seg0, S0);
      check("t3_seg1", seg1, S0);
      do_start();
      check("start_in_post", 8'(post_sig), 8'd1);
      check("start_in_post_gen", 8'(gen_en), 8'd0);
      start = 1'b1;
      lvl_done = 1'b1;
      step();
      start = 1'b0;
      lvl_done = 1'b0;
      check_idle("post_exit", 8'd2, 8'd0);
      step();
      check("stay_idle_gen", 8'(gen_en), 8'd0);
      do_tick();
      check("tick_idle_seg1", seg1, SB);

      // Magic counting: 5 magic, 4 non-magic
      do_start();
      check("m_clear", magic_cnt, 8'd0);
      for (int i = 0; i < 9; i++) begin
         sym_valid = 1'b1;
         sym_magic = ((i % 2) == 0);
         step();
      end
      sym_valid = 1'b0;
      sym_magic = 1'b0;
      check("m_count5", magic_cnt, 8'd5);
      do_tick();
      do_tick();
      do_tick();
      check("m_post", 8'(post_sig), 8'd1);
      sym_valid = 1'b1;
      sym_magic = 1'b1;
      step();
      step();
      sym_valid = 1'b0;
      sym_magic = 1'b0;
      check("m_post_hold", magic_cnt, 8'd5);
      do_done();
      check("m_idle_cnt", magic_cnt, 8'd5);
      check("m_idle_lvl", 8'(level), 8'd3);
      sym_valid = 1'b1;
      sym_magic = 1'b1;
      step();
      sym_valid = 1'b0;
      sym_magic = 1'b0;
      check("m_idle_sym", magic_cnt, 8'd5);

      // Reset mid-PLAY with count 7, level 3
      do_start();
      check("r_clear", magic_cnt, 8'd0);
      sym_valid = 1'b1;
      sym_magic = 1'b1;
      for (int i = 0; i < 7; i++) step();
      sym_valid = 1'b0;
      sym_magic = 1'b0;
      check("r_cnt7", magic_cnt, 8'd7);
      check("r_lvl3", 8'(level), 8'd3);
      check("r_gen",  8'(gen_en), 8'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_idle("midplay_rst", 8'd1, 8'd0);
      step();
      check("after_rst_post", 8'(post_sig), 8'd0);

      // Magic symbol on the final-tick cycle
      do_start();
      do_tick();
      do_tick();
      tick = 1'b1;
      sym_valid = 1'b1;
      sym_magic = 1'b1;
      step();
      tick = 1'b0;
      sym_valid = 1'b0;
      sym_magic = 1'b0;
      check("final_tick_cnt",  magic_cnt, 8'd1);
      check("final_tick_post", 8'(post_sig), 8'd1);
      do_done();
      check("final_tick_lvl", 8'(level), 8'd2);

      // Saturation at 99
      do_start();
      sym_valid = 1'b1;
      sym_magic = 1'b1;
      for (int i = 0; i < 99; i++) step();
      check("sat_99", magic_cnt, 8'd99);
      for (int i = 0; i < 21; i++) step();
      sym_valid = 1'b0;
      sym_magic = 1'b0;
      check("sat_120", magic_cnt, 8'd99);
      do_tick();
      do_tick();
      do_tick();
      do_done();
      check("sat_hold", magic_cnt, 8'd99);

      // Level advance over ten rounds from level 1
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("lv_reset", 8'(level), 8'd1);
      exp_lvl = 8'd1;
      for (int r = 0; r < 10; r++) begin
         do_start();
         do_tick();
         do_tick();
         do_tick();
         check($sformatf("lv%0d_post_hi", r), 8'(post_sig), 8'd1);
         do_done();
         exp_lvl = (exp_lvl < 8'd9) ? exp_lvl + 8'd1 : 8'd9;
         check($sformatf("lv%0d_post_lo", r), 8'(post_sig), 8'd0);
         check($sformatf("lv%0d_level", r), 8'(level), exp_lvl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/level_play_ctrl.md
LEVEL_PLAY_CTRL -- requirements
Module: level_play_ctrl

Interface
REQ-001 SHALL have parameter PLAY_SECONDS, default 20, giving play-period length in seconds (legal range 1..99).
REQ-002 SHALL have parameter MAX_LEVEL, default 9, giving the highest level number reached (legal range 1..15).
REQ-003 SHALL have port Clk100M  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tick1Hz  input  1  one-cycle strobe, once per second, synchronous to Clk100M.
REQ-006 SHALL have port startSig  input  1  player start request, level-sensitive.
REQ-007 SHALL have port symValid  input  1  a new symbol was generated this cycle.
REQ-008 SHALL have port symIsMagic  input  1  the symbol qualified by symValid is the desired symbol.
REQ-009 SHALL have port levelComplete  input  1  one-cycle pulse from the post-period block ending the post period.
REQ-010 SHALL have port postSig  output  1  post-period request, held high for the whole post period.
REQ-011 SHALL have port genEnable  output  1  enables the symbol generator during play.
REQ-012 SHALL have port magicSymbolCount  output  8  desired symbols counted in the current or most recent play period.
REQ-013 SHALL have port level  output  4  current level number.
REQ-014 SHALL have ports timeSeg0 and timeSeg1  output  8 each  active-low seven-segment tens and units digits of the seconds remaining.

Function
REQ-015 SHALL implement three states: IDLE, PLAY and POST.
REQ-016 In IDLE, startSig=1 SHALL cause PLAY on the next cycle, with timeLeft=PLAY_SECONDS, magicSymbolCount=0 and genEnable=1 in that same cycle.
REQ-017 In PLAY, each tick1Hz SHALL decrement timeLeft by 1.
REQ-018 In PLAY, tick1Hz with timeLeft==1 SHALL cause POST on the next cycle, with timeLeft=0, genEnable=0 and postSig=1.
REQ-019 magicSymbolCount SHALL increment by 1 on every cycle with state==PLAY and symValid&&symIsMagic, including the cycle of the final tick.
REQ-020 magicSymbolCount SHALL saturate at 99 (8'd99) and never wrap.
REQ-021 symValid with symIsMagic=0, or any symValid outside PLAY, SHALL NOT change magicSymbolCount.
REQ-022 postSig SHALL be 1 exactly while state==POST, and 0 in IDLE and PLAY.
REQ-023 In POST, levelComplete=1 SHALL cause IDLE on the next cycle, postSig=0, and level = min(level+1, MAX_LEVEL).
REQ-024 levelComplete SHALL be ignored in IDLE and PLAY.
REQ-025 startSig SHALL be ignored in PLAY and POST.
REQ-026 tick1Hz SHALL be ignored in IDLE and POST.
REQ-027 magicSymbolCount SHALL hold its value through POST and the following IDLE, and clear only on the next entry to PLAY.
REQ-028 When startSig and levelComplete arrive in the same POST cycle, the FSM SHALL go to IDLE only; a new PLAY needs startSig in IDLE.
REQ-029 timeSeg0/timeSeg1 SHALL show timeLeft/10 and timeLeft%10 in the team's standard intToSeg digit encoding in PLAY and POST.
REQ-030 timeSeg0/timeSeg1 SHALL be blank (8'hFF) in IDLE.
REQ-031 All outputs SHALL be registered, each updating one cycle after the causing input edge.

Reset
REQ-032 Reset=1 SHALL force, on the next clock edge: state IDLE, timeLeft=0, magicSymbolCount=0, level=1, postSig=0, genEnable=0, timeSeg0=timeSeg1=8'hFF.
REQ-033 Reset SHALL take priority over every other input in any state.
REQ-034 Reset SHALL abort PLAY or POST without a postSig pulse.

Verification
REQ-035 Start with PLAY_SECONDS=3: start pulse, then 3 ticks -> genEnable 1 for the PLAY cycles; postSig rises one cycle after the 3rd tick; timeSeg shows 03,02,01,00.
REQ-036 Magic counting: 5 magic and 4 non-magic symbols in PLAY, plus 2 magic in POST -> magicSymbolCount=5, held after levelComplete.
REQ-037 Saturation: 120 magic symbols in one PLAY -> magicSymbolCount=99, with no wrap.
REQ-038 Level advance: ten full start/play/levelComplete rounds with MAX_LEVEL=9 -> level 1,2,...,9,9; postSig falls one cycle after each levelComplete.
REQ-039 Boundary: magic symbol on the final-tick cycle is counted; levelComplete in PLAY and startSig in POST have no effect.
REQ-040 Reset mid-PLAY with count=7 and level=3 -> next cycle IDLE, count 0, level 1, segments 8'hFF, postSig never asserted.
